// File: rtl/id_redirect_unit_pkg.sv
// id_redirect_unit_pkg: shared types and constants for the decode-stage redirect unit.
package id_redirect_unit_pkg;
  localparam int XLEN_DEFAULT = 32;
  // JALR clears bit 0 of the sum; wide enough for any supported XLEN.
  localparam logic [63:0] JALR_MASK = ~64'd1;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_FLUSH
  } redirect_state_e;
endpackage

// File: rtl/id_redirect_unit_target_calc.sv
// id_target_calc: combinational branch/JAL/JALR target with JALR > JAL > branch priority.
module id_target_calc
  import id_redirect_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_val_i,
  output logic            xfer_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);
  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] reg_rel;
  assign pc_rel       = pc_i + imm_i;
  assign reg_rel      = (rs1_val_i + imm_i) & JALR_MASK[XLEN-1:0];
  assign xfer_o       = is_jalr_i | is_jal_i | (is_branch_i & branch_taken_i);
  assign target_o     = is_jalr_i ? reg_rel : pc_rel;
  assign misaligned_o = target_o[1];
endmodule

// File: rtl/id_redirect_unit.sv
// id_redirect_unit: registers branch/jump targets and hands them to IF with stall and squash.
// Optional misaligned-target trap enabled by defining ID_MISALIGN_TRAP_EN.
module id_redirect_unit
  import id_redirect_unit_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] link_addr,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_target,
  output logic            id_stall,
  output logic            squash_if,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_tval
);
  // A zero-cycle flush never uses the counter; keep it one bit wide.
  localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  redirect_state_e state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] target_q, target_d;
  logic            rv_q, stall_q, squash_q;
  logic            xfer, misaligned, take, trap_hit;
  id_target_calc #(.XLEN(XLEN)) u_calc (
    .is_branch_i   (is_branch),
    .is_jal_i      (is_jal),
    .is_jalr_i     (is_jalr),
    .branch_taken_i(branch_taken),
    .pc_i          (pc),
    .imm_i         (imm),
    .rs1_val_i     (rs1_val),
    .xfer_o        (xfer),
    .target_o      (target_d),
    .misaligned_o  (misaligned)
  );
  // Only IDLE accepts: PENDING stalls decode and FLUSH sees wrong-path instructions.
  assign take            = id_valid & (state_q == ST_IDLE) & xfer;
  assign link_addr       = pc + XLEN'(4);
  assign redirect_valid  = rv_q;
  assign redirect_target = target_q;
  assign id_stall        = stall_q;
  assign squash_if       = squash_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      rv_q     <= 1'b0;
      stall_q  <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (take && !trap_hit) begin
          state_q  <= ST_PENDING;
          target_q <= target_d;
          rv_q     <= 1'b1;
          stall_q  <= 1'b1;
        end
        ST_PENDING: if (redirect_ready) begin
          rv_q    <= 1'b0;
          stall_q <= 1'b0;
          if (FLUSH_CYCLES == 0) state_q <= ST_IDLE;
          else begin
            state_q  <= ST_FLUSH;
            squash_q <= 1'b1;
            cnt_q    <= CW'(FLUSH_CYCLES);
          end
        end
        ST_FLUSH: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q  <= ST_IDLE;
            squash_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
`ifdef ID_MISALIGN_TRAP_EN
  logic            trap_valid_q;
  logic [XLEN-1:0] trap_tval_q;
  assign trap_hit   = misaligned;
  assign trap_valid = trap_valid_q;
  assign trap_tval  = trap_tval_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_valid_q <= 1'b0;
      trap_tval_q  <= '0;
    end else begin
      trap_valid_q <= take & misaligned;
      if (take && misaligned) trap_tval_q <= target_d;
    end
  end
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign trap_hit   = 1'b0;
  assign trap_valid = 1'b0;
  assign trap_tval  = '0;
`endif
endmodule

// File: doc/id_redirect_unit.md
# id_redirect_unit

Decode-stage control-transfer unit for the RV32 core; successor to the ID-stage jump-target select. Computes branch, JAL and JALR targets from decoded operands and registers the chosen target. Presents the target to the fetch stage through a valid/ready handshake and stalls decode while a redirect is outstanding. Squashes wrong-path fetch for a configurable number of cycles and optionally traps misaligned targets.

## Interface
Parameters:
- XLEN, 32, datapath and address width.
- FLUSH_CYCLES, 1, cycles of `squash_if` after the redirect handshake. Legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  a valid instruction is in ID.
- is_branch  in  1  conditional branch.
- is_jal  in  1  JAL.
- is_jalr  in  1  JALR.
- branch_taken  in  1  branch comparison result; ignored unless `is_branch`.
- pc  in  XLEN  PC of the ID instruction.
- imm  in  XLEN  sign-extended immediate.
- rs1_val  in  XLEN  forwarded rs1 value.
- link_addr  out  XLEN  pc+4, combinational, used for rd writeback.
- redirect_valid  out  1  a registered redirect is offered to IF.
- redirect_ready  in  1  IF accepts the redirect.
- redirect_target  out  XLEN  new fetch PC.
- id_stall  out  1  hold the ID stage.
- squash_if  out  1  kill the IF/ID instruction.
- trap_valid  out  1  one-cycle misaligned-target trap pulse.
- trap_tval  out  XLEN  offending target.

## Operation
- `take = id_valid & !id_stall & (is_jal | is_jalr | (is_branch & branch_taken))`.
- If more than one of `is_branch`, `is_jal` and `is_jalr` is set, priority is JALR > JAL > branch.
- Branch and JAL target = (pc + imm) mod 2^XLEN.
- JALR target = ((rs1_val + imm) mod 2^XLEN) & ~1.
- Wrap-around is silent.
- States:
  - IDLE: on `take`, latch the target and go to PENDING.
  - PENDING: `redirect_valid`=1 and `id_stall`=1. `redirect_target` is stable until the handshake (`redirect_valid & redirect_ready`). After the handshake, go to FLUSH, or to IDLE if FLUSH_CYCLES=0.
  - FLUSH: `squash_if`=1 and `id_stall`=0. A down-counter loaded with FLUSH_CYCLES counts down; when it reaches 1, go to IDLE. Counter width is $clog2(FLUSH_CYCLES+1).
- Decode inputs are ignored while `id_stall`=1. Upstream holds the instruction.
- In FLUSH, `take` is suppressed because the ID instruction is wrong-path.
- `rst` in any state returns to IDLE the same edge and discards any pending redirect.
- Reset values: `redirect_valid`=0, `redirect_target`=0, `id_stall`=0, `squash_if`=0, `trap_valid`=0, `trap_tval`=0, counter=0.

## Timing
- `take` in cycle N → `redirect_valid`=1 and `id_stall`=1 from cycle N+1.
- `redirect_ready` is sampled every cycle in PENDING. A handshake in cycle M → `squash_if` high in cycles M+1..M+FLUSH_CYCLES, and `redirect_valid` low from M+1.
- `redirect_ready` outside PENDING has no effect.
- Minimum spacing between redirects is 2+FLUSH_CYCLES cycles.
- `link_addr` has zero latency.

## Configuration
- `ID_MISALIGN_TRAP_EN` defined:
  - A `take` whose target has bit[1]=1 does not enter PENDING.
  - Instead, `trap_valid` pulses in cycle N+1 with `trap_tval`=target, and the state stays IDLE.
- `ID_MISALIGN_TRAP_EN` undefined:
  - The target is redirected unchanged.
  - `trap_valid` and `trap_tval` are tied to 0; the ports are always present.

## Structure
- The shared core package holds the state enum (IDLE, PENDING, FLUSH), the XLEN default and the ~1 JALR mask constant.
- One sub-module, `id_target_calc`: combinational target computation and priority select. It also supplies the bit[1] check used by the misalignment trap.
- The state machine and counter live in the top module.

## Test plan
- JAL, pc=0x100, imm=0x20, `redirect_ready`=1 → `redirect_target`=0x120 in cycle N+1, `squash_if` for 1 cycle, `link_addr`=0x104.
- JALR, rs1_val=0x2003, imm=0x4 → target 0x2006 (bit 0 cleared). Hold `redirect_ready`=0 for 3 cycles → target stable and `id_stall`=1 throughout.
- Branch, pc=0xFFFFFFF8, imm=0x10, taken → target 0x8 (wrap-around). Same inputs with not-taken → no `redirect_valid`.
- FLUSH_CYCLES=3, second JAL presented during FLUSH → ignored. `squash_if` high exactly 3 cycles, then IDLE.
- `rst` asserted in PENDING with target 0x400 → next cycle all outputs 0, no handshake completes.
- With `ID_MISALIGN_TRAP_EN`: JAL pc=0x0, imm=0x6 → `trap_valid`=1 for one cycle, `trap_tval`=0x6, no redirect. Without the macro → redirect to 0x6.
